perf_router: RTL and testbench

Parametrised CPU data-memory router that fans one CPU load/store port out to `N_CH` memory-mapped targets, such as data memory and performance-counter banks. Its sequential read-return path is latency-matched, so the read data returned to the CPU comes from the target that was addressed `RD_LAT` cycles earlier. It also flags accesses to unmapped channels and can count accesses per channel. It sits between the CPU pipeline's memory stage and the target memories/peripherals.

---
 rtl/perf_router.sv | 115 +++++++++++
 tb/tb_perf_router.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_router.sv
// perf_router: fans one CPU load/store port out to N_CH mapped targets.
// Read return is latency-matched; PERF_ROUTER_ACCESS_CNT_EN adds counters.
module perf_router #(
  parameter int N_CH       = 4,
  parameter int DW         = 64,
  parameter int AW         = 64,
  parameter int RD_LAT     = 1,
  parameter int ADDR_SHIFT = 3,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        cpu_din,
  input  logic [AW-1:0]        cpu_ain,
  input  logic                 cpu_wren,
  input  logic                 cpu_rden,
  output logic [DW-1:0]        cpu_dout,
  output logic                 cpu_rvalid,
  output logic                 err,
  output logic [N_CH*DW-1:0]   dout_bus,
  output logic [N_CH*AW-1:0]   aout_bus,
  output logic [N_CH-1:0]      wrout_bus,
`ifdef PERF_ROUTER_ACCESS_CNT_EN
  output logic [N_CH*2*CNT_W-1:0] cnt_bus,
`endif
  input  logic [N_CH*DW-1:0]   din_bus
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LST   = RD_LAT - 1;

  logic [SEL_W-1:0] w_sel;
  logic             w_map;
  logic [AW-1:0]    w_aword;
  logic [N_CH-1:0]  w_hit;

  assign w_sel   = cpu_ain[AW-1 -: SEL_W];
  assign w_map   = {1'b0, w_sel} < (SEL_W+1)'(N_CH);
  assign w_aword = {{SEL_W{1'b0}}, cpu_ain[AW-SEL_W-1:0]} >> ADDR_SHIFT;

  for (genvar k = 0; k < N_CH; k++) begin : g_req
    assign w_hit[k] = w_map && (w_sel == SEL_W'(k));
    assign dout_bus[k*DW +: DW] = w_hit[k] ? cpu_din : '0;
    assign aout_bus[k*AW +: AW] = w_hit[k] ? w_aword : '0;
    assign wrout_bus[k]         = w_hit[k] & cpu_wren;
  end

  // Each stage remembers which target a load addressed, so the
  // return mux follows the load rather than the current address.
  logic [RD_LAT-1:0]            r_vld;
  logic [RD_LAT-1:0]            r_map;
  logic [RD_LAT-1:0][SEL_W-1:0] r_sel;
  logic                         r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_map <= '0;
      r_sel <= '0;
      r_err <= 1'b0;
    end else begin
      r_vld[0] <= cpu_rden;
      r_map[0] <= w_map;
      r_sel[0] <= w_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_map[i] <= r_map[i-1];
        r_sel[i] <= r_sel[i-1];
      end
      if ((cpu_wren | cpu_rden) && !w_map) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    cpu_dout = '0;
    if (r_vld[LST] && r_map[LST]) begin
      for (int k = 0; k < N_CH; k++) begin
        if (r_sel[LST] == SEL_W'(k)) begin
          cpu_dout = din_bus[k*DW +: DW];
        end
      end
    end
  end

  assign cpu_rvalid = r_vld[LST];
  assign err        = r_err;

`ifdef PERF_ROUTER_ACCESS_CNT_EN
  logic [N_CH-1:0][CNT_W-1:0] r_wr_cnt;
  logic [N_CH-1:0][CNT_W-1:0] r_rd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_hit[k] && cpu_wren) begin
          r_wr_cnt[k] <= r_wr_cnt[k] + CNT_W'(1);
        end
        if (w_hit[k] && cpu_rden) begin
          r_rd_cnt[k] <= r_rd_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    assign cnt_bus[k*2*CNT_W +: 2*CNT_W] = {r_rd_cnt[k], r_wr_cnt[k]};
  end
`endif

endmodule

// File: tb/tb_perf_router.sv
// tb_perf_router: two router builds (4ch/lat2, 3ch/lat3) on shared
// CPU inputs, checked every cycle against a history-based model.
module tb_perf_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wren, rden;
  logic [63:0] din, ain;

  logic [255:0] a_dout, a_aout, a_din;
  logic [3:0]   a_wr;
  logic [63:0]  a_rd;
  logic         a_rv, a_err;

  logic [191:0] b_dout, b_aout, b_din;
  logic [2:0]   b_wr;
  logic [63:0]  b_rd;
  logic         b_rv, b_err;

`ifdef PERF_ROUTER_ACCESS_CNT_EN
  logic [31:0] a_cnt;
  logic [23:0] b_cnt;
`endif

  logic [63:0] a_val [4];
  logic [63:0] b_val [3];

  initial begin
    a_val[0] = 64'h0A;
    a_val[1] = 64'h1111;
    a_val[2] = 64'h2222;
    a_val[3] = 64'h3C;
    b_val[0] = 64'hB0;
    b_val[1] = 64'h1111;
    b_val[2] = 64'hB2;
  end

  assign a_din = {a_val[3], a_val[2], a_val[1], a_val[0]};
  assign b_din = {b_val[2], b_val[1], b_val[0]};

  perf_router #(
    .N_CH(4), .DW(64), .AW(64), .RD_LAT(2),
    .ADDR_SHIFT(3), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .cpu_din(din), .cpu_ain(ain),
    .cpu_wren(wren), .cpu_rden(rden),
    .cpu_dout(a_rd), .cpu_rvalid(a_rv), .err(a_err),
    .dout_bus(a_dout), .aout_bus(a_aout), .wrout_bus(a_wr),
`ifdef PERF_ROUTER_ACCESS_CNT_EN
    .cnt_bus(a_cnt),
`endif
    .din_bus(a_din)
  );

  perf_router #(
    .N_CH(3), .DW(64), .AW(64), .RD_LAT(3),
    .ADDR_SHIFT(3), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst),
    .cpu_din(din), .cpu_ain(ain),
    .cpu_wren(wren), .cpu_rden(rden),
    .cpu_dout(b_rd), .cpu_rvalid(b_rv), .err(b_err),
    .dout_bus(b_dout), .aout_bus(b_aout), .wrout_bus(b_wr),
`ifdef PERF_ROUTER_ACCESS_CNT_EN
    .cnt_bus(b_cnt),
`endif
    .din_bus(b_din)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Cycle history of the CPU side; the model reads it back by cycle.
  int       cyc = 0;
  bit       h_rst [512];
  bit       h_rd  [512];
  bit [1:0] h_sel [512];
  bit       m_err_a, m_err_b;
  int       m_wr_a [4], m_rd_a [4];
  int       m_wr_b [3], m_rd_b [3];

  always @(posedge clk) begin
    h_rst[cyc] <= rst;
    h_rd[cyc]  <= rden;
    h_sel[cyc] <= ain[63:62];
    if (rst) begin
      m_err_a <= 1'b0;
      m_err_b <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_wr_a[k] <= 0;
        m_rd_a[k] <= 0;
      end
      for (int k = 0; k < 3; k++) begin
        m_wr_b[k] <= 0;
        m_rd_b[k] <= 0;
      end
    end else begin
      if ((wren | rden) && ain[63:62] >= 2'd3) m_err_b <= 1'b1;
      if (wren) m_wr_a[ain[63:62]] <= (m_wr_a[ain[63:62]] + 1) % 16;
      if (rden) m_rd_a[ain[63:62]] <= (m_rd_a[ain[63:62]] + 1) % 16;
      if (ain[63:62] < 2'd3) begin
        if (wren) m_wr_b[ain[63:62]] <= (m_wr_b[ain[63:62]] + 1) % 16;
        if (rden) m_rd_b[ain[63:62]] <= (m_rd_b[ain[63:62]] + 1) % 16;
      end
    end
    cyc <= cyc + 1;
  end

  // A load issued in cycle c-L returns in cycle c unless any reset
  // was sampled in cycles c-L .. c-1.
  function automatic void exp_ret(input int lat, input int n, input int c,
                                  output bit v, output int ch, output bit mp);
    v  = 1'b0;
    ch = 0;
    mp = 1'b0;
    if (c >= lat) begin
      v  = h_rd[c-lat];
      ch = int'(h_sel[c-lat]);
      mp = ch < n;
      for (int j = c - lat; j < c; j++) if (h_rst[j]) v = 1'b0;
    end
  endfunction

  function automatic logic [255:0] exp_req(input int n, input int kind);
    logic [255:0] r;
    int           s;
    r = '0;
    s = int'(ain[63:62]);
    if (s < n) begin
      if (kind == 0) r[s*64 +: 64] = din;
      if (kind == 1) r[s*64 +: 64] = (ain & 64'h3FFF_FFFF_FFFF_FFFF) >> 3;
      if (kind == 2) r[s] = wren;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    bit          v, mp;
    int          ch;
    logic [63:0] d;
    if (cyc >= 1) begin
      exp_ret(2, 4, cyc, v, ch, mp);
      d = (v && mp) ? a_val[ch] : 64'h0;
      chk("a_rvalid", 256'(a_rv), 256'(v));
      chk("a_dout", 256'(a_rd), 256'(d));
      chk("a_err", 256'(a_err), 256'(m_err_a));
      chk("a_dbus", a_dout, exp_req(4, 0));
      chk("a_abus", a_aout, exp_req(4, 1));
      chk("a_wbus", 256'(a_wr), exp_req(4, 2));
      exp_ret(3, 3, cyc, v, ch, mp);
      d = (v && mp) ? b_val[ch] : 64'h0;
      chk("b_rvalid", 256'(b_rv), 256'(v));
      chk("b_dout", 256'(b_rd), 256'(d));
      chk("b_err", 256'(b_err), 256'(m_err_b));
      chk("b_dbus", 256'(b_dout), exp_req(3, 0));
      chk("b_abus", 256'(b_aout), exp_req(3, 1));
      chk("b_wbus", 256'(b_wr), exp_req(3, 2));
`ifdef PERF_ROUTER_ACCESS_CNT_EN
      for (int k = 0; k < 4; k++)
        chk("a_cnt", 256'(a_cnt[k*8 +: 8]),
            256'((m_rd_a[k] << 4) | m_wr_a[k]));
      for (int k = 0; k < 3; k++)
        chk("b_cnt", 256'(b_cnt[k*8 +: 8]),
            256'((m_rd_b[k] << 4) | m_wr_b[k]));
`endif
    end
  end

  localparam logic [63:0] A0 = 64'h0000_0000_0000_0040;
  localparam logic [63:0] A1 = 64'h4000_0000_0000_0008;
  localparam logic [63:0] A2 = 64'h8000_0000_0000_0010;
  localparam logic [63:0] A3 = 64'hC000_0000_0000_1238;

  task automatic step(input bit r, input bit w, input bit rd,
                      input logic [63:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    rst  = r;
    wren = w;
    rden = rd;
    ain  = a;
    din  = d;
  endtask

  initial begin
    rst  = 1'b1;
    wren = 1'b0;
    rden = 1'b0;
    ain  = '0;
    din  = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_a_rvalid", 256'(a_rv), 256'(0));
    chk("rst_b_dout", 256'(b_rd), 256'(0));
    chk("rst_b_err", 256'(b_err), 256'(0));
    step(0, 0, 0, 0, 0);

    // write routing to channel 2
    step(0, 1, 0, A2, 64'hA5);
    @(negedge clk);
    chk("wr_route_wr", 256'(a_wr), 256'(4'b0100));
    chk("wr_route_aout", a_aout, {64'h0, 64'h2, 64'h0, 64'h0});
    chk("wr_route_dout", a_dout, {64'h0, 64'hA5, 64'h0, 64'h0});

    // single load from channel 1
    step(0, 0, 1, A1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_a_hit", 256'({a_rv, a_rd}), {1'b1, 64'h1111});
    chk("lat_b_early", 256'(b_rv), 256'(0));
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_b_hit", 256'({b_rv, b_rd}), {1'b1, 64'h1111});
    chk("lat_a_after", 256'(a_rv), 256'(0));
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_b_after", 256'(b_rv), 256'(0));

    // back-to-back loads ch0, ch3, ch0
    step(0, 0, 1, A0, 0);
    step(0, 0, 1, A3, 0);
    step(0, 0, 1, A0, 0);
    @(negedge clk);
    chk("b2b_a_0", 256'({a_rv, a_rd}), {1'b1, 64'h0A});
    chk("unm_b_err", 256'(b_err), 256'(1));
    chk("unm_a_err", 256'(a_err), 256'(0));
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_a_1", 256'({a_rv, a_rd}), {1'b1, 64'h3C});
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_a_2", 256'({a_rv, a_rd}), {1'b1, 64'h0A});
    chk("unm_b_ret", 256'({b_rv, b_rd}), {1'b1, 64'h0});
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("unm_b_hold", 256'(b_err), 256'(1));

    // counters from a clean reset
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, A0, 64'(i));
    step(0, 1, 1, A1, 64'h77);
    step(0, 0, 0, 0, 0);
`ifdef PERF_ROUTER_ACCESS_CNT_EN
    @(negedge clk);
    chk("cnt_a", 256'(a_cnt[15:0]), 256'(16'h1101));
    chk("cnt_b", 256'(b_cnt[15:0]), 256'(16'h1101));
`endif

    // reset with a load in flight, then a load right after reset
    step(0, 1, 0, A3, 64'h55);
    step(0, 0, 1, A1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, A2, 0);
    @(negedge clk);
    chk("mid_b_drop", 256'(b_rv), 256'(0));
    chk("mid_b_err", 256'(b_err), 256'(0));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_b_ret", 256'({b_rv, b_rd}), {1'b1, 64'hB2});
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
